mem_wait_ctrl: RTL

- Data-memory access controller that sits directly upstream of the wait-stage register bank.
- Takes a load/store from the MEM stage and issues it on an SRAM-like req/addr_ok/data_ok bus.
- Stalls the pipeline until the data returns, then drives the bank's enable with captured load data.
- Also handles store-data alignment, misalignment faults, flush cancellation and a stall-cycle counter.

---
 rtl/mem_wait_ctrl_pkg.sv | 18 +
 rtl/mem_wait_ctrl_if.sv | 23 ++
 rtl/mem_wait_ctrl_store_align.sv | 25 ++
 rtl/mem_wait_ctrl.sv | 127 ++++++++++++
 4 files changed

// File: rtl/mem_wait_ctrl_pkg.sv
// Shared types and constants for the data-memory wait-stage controller.
package mem_wait_ctrl_pkg;

    localparam int unsigned DATA_W = 32;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ADDR  = 3'd1,
        DATA  = 3'd2,
        RESP  = 3'd3,
        DRAIN = 3'd4
    } state_t;

endpackage

// File: rtl/mem_wait_ctrl_if.sv
// SRAM-like data bus: req/addr_ok address phase, data_ok data phase.
interface mem_wait_ctrl_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              data_req;
    logic              data_wr;
    logic [1:0]        data_size;
    logic [ADDR_W-1:0] data_addr;
    logic [31:0]       data_wdata;
    logic              data_addr_ok;
    logic              data_data_ok;
    logic [31:0]       data_rdata;

    modport master (
        output data_req, data_wr, data_size, data_addr, data_wdata,
        input  data_addr_ok, data_data_ok, data_rdata
    );

    modport slave (
        input  data_req, data_wr, data_size, data_addr, data_wdata,
        output data_addr_ok, data_data_ok, data_rdata
    );
endinterface

// File: rtl/mem_wait_ctrl_store_align.sv
// Store-data lane replication and alignment check for byte/half/word accesses.
module mem_store_align
    import mem_wait_ctrl_pkg::*;
(
    input  logic [1:0]        size,
    input  logic [1:0]        addr_lo,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] wdata_rep,
    output logic              misaligned
);

    always_comb begin
        wdata_rep  = wdata;
        misaligned = 1'b0;
        case (size)
            SIZE_B: wdata_rep = {4{wdata[7:0]}};
            SIZE_H: begin
                wdata_rep  = {2{wdata[15:0]}};
                misaligned = addr_lo[0];
            end
            default: misaligned = (addr_lo != 2'b00);
        endcase
    end

endmodule

// File: rtl/mem_wait_ctrl.sv
// Issues MEM-stage loads/stores on the data bus and stalls the pipeline until they finish.
module mem_wait_ctrl
    import mem_wait_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W  = 32,
    parameter int unsigned ADDR_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mem_valid,
    input  logic               mem_wen,
    input  logic [1:0]         mem_size,
    input  logic [ADDR_W-1:0]  mem_addr,
    input  logic [DATA_W-1:0]  mem_wdata,
    input  logic               flush,
    input  logic               stall_in,
    mem_wait_ctrl_if.master    bus,
    output logic               stall_req,
    output logic               wait_en,
    output logic [DATA_W-1:0]  rdata_out,
    output logic               rdata_valid,
    output logic               addr_err,
    output logic [CNT_W-1:0]   stall_cnt
);

    state_t             state;
    state_t             state_nx;
    logic               accept;
    logic               fault;
    logic               misaligned;
    logic [DATA_W-1:0]  wdata_rep;

    logic               req_q;
    logic               wr_q;
    logic [1:0]         size_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [DATA_W-1:0]  wdata_q;

    mem_store_align u_align (
        .size       (mem_size),
        .addr_lo    (mem_addr[1:0]),
        .wdata      (mem_wdata),
        .wdata_rep  (wdata_rep),
        .misaligned (misaligned)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // addr_ok wins over flush in ADDR; flush in DATA without data_ok must drain the response.
    always_comb begin
        state_nx  = state;
        stall_req = 1'b0;
        accept    = 1'b0;
        fault     = 1'b0;
        case (state)
            IDLE: begin
                if (mem_valid && !flush) begin
                    if (misaligned) begin
                        fault = 1'b1;
                    end else begin
                        accept    = 1'b1;
                        stall_req = 1'b1;
                        state_nx  = ADDR;
                    end
                end
            end
            ADDR: begin
                stall_req = 1'b1;
                if (bus.data_addr_ok) state_nx = DATA;
                else if (flush)       state_nx = IDLE;
            end
            DATA: begin
                stall_req = 1'b1;
                if (bus.data_data_ok) state_nx = flush ? IDLE : RESP;
                else if (flush)       state_nx = DRAIN;
            end
            RESP: begin
                if (!stall_in) state_nx = IDLE;
            end
            DRAIN: begin
                stall_req = 1'b1;
                if (bus.data_data_ok) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign wait_en = !stall_req && !stall_in;

    always_ff @(posedge clk) begin
        if (rst) begin
            req_q       <= 1'b0;
            wr_q        <= 1'b0;
            size_q      <= 2'b00;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_out   <= '0;
            rdata_valid <= 1'b0;
            addr_err    <= 1'b0;
            stall_cnt   <= '0;
        end else begin
            req_q       <= (state_nx == ADDR);
            addr_err    <= fault;
            rdata_valid <= (state_nx == RESP) && !wr_q;
            if (accept) begin
                wr_q    <= mem_wen;
                size_q  <= mem_size;
                addr_q  <= mem_addr;
                wdata_q <= wdata_rep;
            end
            if (state == DATA && bus.data_data_ok && !flush && !wr_q)
                rdata_out <= bus.data_rdata;
            if (stall_req && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    assign bus.data_req   = req_q;
    assign bus.data_wr    = wr_q;
    assign bus.data_size  = size_q;
    assign bus.data_addr  = addr_q;
    assign bus.data_wdata = wdata_q;

endmodule
